// File: rtl/rx_jitter_buffer.sv
// Receive playout buffer: prefills a circular sample store, then feeds one sample per DAC transfer.
// Optional JITTER_HOLD_LAST_EN repeats the last popped sample on underrun instead of silence.
module rx_jitter_buffer #(
  parameter int DEPTH   = 64,
  parameter int PREFILL = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [15:0]              wr_data,
  input  logic                     wr_valid,
  input  logic                     dac_ready,
  output logic [15:0]              dac_data,
  output logic                     dac_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     playing,
  output logic                     overflow,
  output logic [15:0]              underrun_cnt,
  output logic [15:0]              overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);
  localparam logic [CW-1:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_PLAY    = 2'd2
  } state_t;

  state_t          state_r, state_next_s;
  logic [15:0]     mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_next_s;
  logic [15:0]     dac_data_r, underrun_cnt_r, overflow_cnt_r, fill_s;
  logic            dac_valid_r, playing_r, overflow_r;
  logic            transfer_s, pop_s, underrun_s, accept_s, drop_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) sat_inc = v;
    else               sat_inc = v + 16'd1;
  endfunction

  assign transfer_s = dac_valid_r && dac_ready;
  assign pop_s      = transfer_s && (state_r == ST_PLAY) && (count_r != {CW{1'b0}});
  assign underrun_s = transfer_s && (state_r == ST_PLAY) && (count_r == {CW{1'b0}});
  // A pop on the same edge frees the slot, so a full buffer can still take a write.
  assign accept_s   = wr_valid && ((count_r != DEPTH_C) || pop_s);
  assign drop_s     = wr_valid && !accept_s;

`ifdef JITTER_HOLD_LAST_EN
  logic [15:0] held_r;
  assign fill_s = held_r;

  // Last popped sample, replayed on underrun.
  always_ff @(posedge clk) begin
    if (rst || flush) held_r <= 16'h0000;
    else if (pop_s)   held_r <= mem_r[rd_ptr_r];
    else              held_r <= held_r;
  end
`else
  assign fill_s = 16'h0000;
`endif

  // Post-update occupancy.
  always_comb begin
    count_next_s = count_r;
    if (accept_s && !pop_s)      count_next_s = count_r + CNT_ONE;
    else if (!accept_s && pop_s) count_next_s = count_r - CNT_ONE;
    else                         count_next_s = count_r;
  end

  // Playback state transitions; flush overrides everything.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) state_next_s = (count_next_s >= PREFILL_C) ? ST_PLAY : ST_PREFILL;
          else          state_next_s = ST_IDLE;
        end
        ST_PREFILL: begin
          if (count_next_s >= PREFILL_C) state_next_s = ST_PLAY;
          else                           state_next_s = ST_PREFILL;
        end
        ST_PLAY: begin
          if (underrun_s) state_next_s = ST_PREFILL;
          else            state_next_s = ST_PLAY;
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Sample storage; never written on a flush or reset edge.
  always_ff @(posedge clk) begin
    if (!rst && !flush && accept_s) mem_r[wr_ptr_r] <= wr_data;
  end

  // Pointers, count, prefetch register, status and diagnostic counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      wr_ptr_r       <= {AW{1'b0}};
      rd_ptr_r       <= {AW{1'b0}};
      count_r        <= {CW{1'b0}};
      dac_data_r     <= 16'h0000;
      dac_valid_r    <= 1'b0;
      playing_r      <= 1'b0;
      overflow_r     <= 1'b0;
      underrun_cnt_r <= 16'h0000;
      overflow_cnt_r <= 16'h0000;
    end else begin
      state_r     <= state_next_s;
      playing_r   <= (state_next_s == ST_PLAY);
      dac_valid_r <= 1'b1;
      overflow_r  <= drop_s && !flush;
      if (flush) begin
        wr_ptr_r   <= {AW{1'b0}};
        rd_ptr_r   <= {AW{1'b0}};
        count_r    <= {CW{1'b0}};
        dac_data_r <= 16'h0000;
      end else begin
        count_r <= count_next_s;
        if (accept_s)   wr_ptr_r <= wr_ptr_r + PTR_ONE;
        if (pop_s)      rd_ptr_r <= rd_ptr_r + PTR_ONE;
        if (transfer_s) dac_data_r <= pop_s ? mem_r[rd_ptr_r] : fill_s;
        if (underrun_s) underrun_cnt_r <= sat_inc(underrun_cnt_r);
        if (drop_s)     overflow_cnt_r <= sat_inc(overflow_cnt_r);
      end
    end
  end

  assign dac_data     = dac_data_r;
  assign dac_valid    = dac_valid_r;
  assign level        = count_r;
  assign playing      = playing_r;
  assign overflow     = overflow_r;
  assign underrun_cnt = underrun_cnt_r;
  assign overflow_cnt = overflow_cnt_r;

endmodule
